instr_encoder: RTL and testbench

Streaming instruction encoder and instruction-memory loader for the 8-bit scalar CPU. It accepts field-level instruction requests (opcode, format, rd, rs1, rs2, imm, addr) over a valid/ready handshake and packs them into the 8-bit instruction word the core decodes. It buffers encoded words in a small FIFO and writes them to consecutive instruction-memory locations through a stallable write port. It sits between the test/boot host and the instruction memory, and is the inverse of the core's instruction decode.

---
 rtl/scpu_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/instr_encoder.sv | 128 ++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_pkg.sv
// Shared encoding constants for the 8-bit scalar CPU: opcodes, formats and
// instruction-word field positions used by both the encoder and the decoder.
package scpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_LI  = 2'b11;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 4;
  localparam int ADDR_HI = 5;
  localparam int ADDR_LO = 2;
  localparam int RS1_HI  = 3;
  localparam int RS1_LO  = 2;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;
  localparam int RS2_HI  = 1;
  localparam int RS2_LO  = 0;

  typedef struct packed {
    logic       legal;
    logic [7:0] word;
  } enc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; storage is left unreset, only the
// pointers are cleared by reset or flush.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 8-bit words, queues them and
// streams them into consecutive instruction-memory locations.
module instr_encoder
  import scpu_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int IMEM_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_fmt,
  input  logic [1:0]         in_op,
  input  logic [1:0]         in_rd,
  input  logic [1:0]         in_rs1,
  input  logic [1:0]         in_rs2,
  input  logic [3:0]         in_imm,
  input  logic [3:0]         in_addr,
  input  logic               restart,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [IMEM_AW-1:0] wr_addr,
  output logic [7:0]         wr_data,
  output logic               wrapped,
  output logic               err,
  output logic [3:0]         err_cnt
);

  function automatic enc_t encode(input logic [1:0] fmt, input logic [1:0] op,
                                  input logic [1:0] rd, input logic [1:0] rs1,
                                  input logic [1:0] rs2, input logic [3:0] imm,
                                  input logic [3:0] addr);
    enc_t e;
    e.legal = 1'b0;
    e.word  = '0;
    case (fmt_e'(fmt))
      FMT_R: begin
        e.word[OP_HI:OP_LO]   = op;
        e.word[RD_HI:RD_LO]   = rd;
        e.word[RS1_HI:RS1_LO] = rs1;
        e.word[RS2_HI:RS2_LO] = rs2;
        e.legal               = (op != OP_LI);
      end
      FMT_I: begin
        // The I format is implied by the LI opcode in the top two bits.
        e.word[OP_HI:OP_LO]   = OP_LI;
        e.word[RD_HI:RD_LO]   = rd;
        e.word[IMM_HI:IMM_LO] = imm;
        e.legal               = (op == OP_LI);
      end
      FMT_J: begin
        e.word[OP_HI:OP_LO]     = op;
        e.word[ADDR_HI:ADDR_LO] = addr;
        e.legal                 = (op != OP_LI);
      end
      default: begin
        e.legal = 1'b0;
      end
    endcase
    return e;
  endfunction

  enc_t               w_enc;
  logic               w_accept;
  logic               w_push;
  logic               w_wr_hs;
  logic               w_full;
  logic               w_empty;
  logic [7:0]         w_head;
  logic [IMEM_AW-1:0] r_wr_addr;
  logic               r_wrapped;
  logic               r_err;
  logic [3:0]         r_err_cnt;

  assign w_enc    = encode(in_fmt, in_op, in_rd, in_rs1, in_rs2, in_imm, in_addr);
  assign in_ready = !w_full;
  assign w_accept = in_valid && !w_full;
  assign w_push   = w_accept && w_enc.legal && !restart;
  assign w_wr_hs  = !w_empty && wr_ready;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (restart),
    .push  (w_push),
    .wdata (w_enc.word),
    .pop   (w_wr_hs),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign wr_en   = !w_empty;
  assign wr_data = w_empty ? 8'h00 : w_head;
  assign wr_addr = r_wr_addr;
  assign wrapped = r_wrapped;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_wrapped <= 1'b0;
    end else if (restart) begin
      r_wr_addr <= '0;
      r_wrapped <= 1'b0;
    end else if (w_wr_hs) begin
      r_wr_addr <= r_wr_addr + 1'b1;
      if (r_wr_addr == {IMEM_AW{1'b1}}) r_wrapped <= 1'b1;
    end
  end

  // Illegal requests are consumed without enqueueing; the count survives restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_accept && !w_enc.legal;
      if (w_accept && !w_enc.legal && (r_err_cnt != 4'hF)) r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, legality, backpressure, address
// wrap, restart and asynchronous reset.
module tb_instr_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_fmt;
  logic [1:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic [3:0] in_imm;
  logic [3:0] in_addr;
  logic       restart;
  logic       wr_en;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wrapped;
  logic       err;
  logic [3:0] err_cnt;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.DEPTH(2), .IMEM_AW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .in_addr  (in_addr),
    .restart  (restart),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wrapped  (wrapped),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [1:0] fmt, input logic [1:0] op,
                     input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                     input logic [3:0] imm, input logic [3:0] addr);
    in_valid = v;
    in_fmt   = fmt;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_addr  = addr;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".wr_en"},    32'(wr_en),    32'd0);
    chk({tag, ".wr_addr"},  32'(wr_addr),  32'd0);
    chk({tag, ".wr_data"},  32'(wr_data),  32'd0);
    chk({tag, ".wrapped"},  32'(wrapped),  32'd0);
    chk({tag, ".err"},      32'(err),      32'd0);
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    restart  = 1'b0;
    wr_ready = 1'b1;
    req(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0);
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R encode: 01 10 01 11 = 0x67, then 00 00 00 01 = 0x01
    req(1'b1, 2'b00, 2'b01, 2'd2, 2'd1, 2'd3, 4'h0, 4'h0);
    tick();
    chk("r.wr_en",   32'(wr_en),   32'd1);
    chk("r.wr_addr", 32'(wr_addr), 32'd0);
    chk("r.wr_data", 32'(wr_data), 32'h67);
    req(1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 2'd1, 4'h0, 4'h0);
    tick();
    chk("r2.wr_en",   32'(wr_en),   32'd1);
    chk("r2.wr_addr", 32'(wr_addr), 32'd1);
    chk("r2.wr_data", 32'(wr_data), 32'h01);
    in_valid = 1'b0;
    tick();
    chk("r2.drain_en",   32'(wr_en),   32'd0);
    chk("r2.drain_addr", 32'(wr_addr), 32'd2);
    chk("r2.drain_data", 32'(wr_data), 32'h00);

    // I encode: 11 01 1010 = 0xDA
    req(1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 2'd0, 4'hA, 4'h0);
    tick();
    in_valid = 1'b0;
    chk("i.wr_data", 32'(wr_data), 32'hDA);
    chk("i.wr_addr", 32'(wr_addr), 32'd2);
    tick();
    chk("i.addr_after", 32'(wr_addr), 32'd3);

    // Illegal: I format with op 00
    req(1'b1, 2'b01, 2'b00, 2'd1, 2'd0, 2'd0, 4'h5, 4'h0);
    tick();
    in_valid = 1'b0;
    chk("ill.err",     32'(err),     32'd1);
    chk("ill.wr_en",   32'(wr_en),   32'd0);
    chk("ill.err_cnt", 32'(err_cnt), 32'd1);
    tick();
    chk("ill.err_drop", 32'(err),    32'd0);
    chk("ill.wr_addr",  32'(wr_addr), 32'd3);

    // 20 more illegal requests (mix of reserved fmt, R/J with LI op)
    req(1'b1, 2'b11, 2'b00, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("ill10.err_cnt", 32'(err_cnt), 32'd11);
    chk("ill10.in_ready", 32'(in_ready), 32'd1);
    req(1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) tick();
    req(1'b1, 2'b10, 2'b11, 2'd0, 2'd0, 2'd0, 4'h0, 4'h3);
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    chk("ill20.err_cnt", 32'(err_cnt), 32'd15);
    chk("ill20.wr_en",   32'(wr_en),   32'd0);
    tick();
    chk("ill20.err_idle", 32'(err), 32'd0);

    // Backpressure: A=0x7F, B=0x14, C=0x98
    wr_ready = 1'b0;
    req(1'b1, 2'b00, 2'b01, 2'd3, 2'd3, 2'd3, 4'h0, 4'h0);
    tick();
    req(1'b1, 2'b10, 2'b00, 2'd0, 2'd0, 2'd0, 4'h0, 4'h5);
    tick();
    chk("bp.in_ready_full", 32'(in_ready), 32'd0);
    chk("bp.wr_en",         32'(wr_en),    32'd1);
    chk("bp.wr_data_a",     32'(wr_data),  32'h7F);
    chk("bp.wr_addr",       32'(wr_addr),  32'd3);
    req(1'b1, 2'b00, 2'b10, 2'd1, 2'd2, 2'd0, 4'h0, 4'h0);
    tick();
    chk("bp.held_ready", 32'(in_ready), 32'd0);
    chk("bp.held_data",  32'(wr_data),  32'h7F);
    chk("bp.held_addr",  32'(wr_addr),  32'd3);
    wr_ready = 1'b1;
    tick();
    chk("bp.w1_addr",  32'(wr_addr),  32'd4);
    chk("bp.w1_data",  32'(wr_data),  32'h14);
    chk("bp.w1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.w2_addr", 32'(wr_addr), 32'd5);
    chk("bp.w2_data", 32'(wr_data), 32'h98);
    chk("bp.w2_en",   32'(wr_en),   32'd1);
    tick();
    chk("bp.w3_addr", 32'(wr_addr), 32'd6);
    chk("bp.w3_en",   32'(wr_en),   32'd0);

    // Restart to bring the address back to 0 before the wrap test
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs0.wr_addr", 32'(wr_addr), 32'd0);
    chk("rs0.err_cnt", 32'(err_cnt), 32'd15);

    // Wrap: 16 J words op 10, addr i -> {10, i, 00}
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 2'b10, 2'b10, 2'd0, 2'd0, 2'd0, 4'h0, 4'(i));
      tick();
      chk($sformatf("wrap%0d.addr", i), 32'(wr_addr), 32'(i));
      chk($sformatf("wrap%0d.data", i), 32'(wr_data), 32'h80 | 32'(i << 2));
    end
    in_valid = 1'b0;
    chk("wrap.last_data",   32'(wr_data), 32'hBC);
    chk("wrap.not_yet",     32'(wrapped), 32'd0);
    tick();
    chk("wrap.addr0",   32'(wr_addr), 32'd0);
    chk("wrap.wrapped", 32'(wrapped), 32'd1);
    chk("wrap.idle",    32'(wr_en),   32'd0);

    // Restart with two words queued and a write handshake in progress
    wr_ready = 1'b0;
    req(1'b1, 2'b00, 2'b01, 2'd2, 2'd1, 2'd3, 4'h0, 4'h0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("rs.full",  32'(in_ready), 32'd0);
    chk("rs.queued", 32'(wr_en),   32'd1);
    wr_ready = 1'b1;
    restart  = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs.wr_en",   32'(wr_en),    32'd0);
    chk("rs.wr_addr", 32'(wr_addr),  32'd0);
    chk("rs.wrapped", 32'(wrapped),  32'd0);
    chk("rs.err_cnt", 32'(err_cnt),  32'd15);
    chk("rs.ready",   32'(in_ready), 32'd1);
    chk("rs.wr_data", 32'(wr_data),  32'h00);
    // Push concurrent with restart is discarded
    req(1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 2'd0, 4'hA, 4'h0);
    restart = 1'b1;
    tick();
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("rs.push_drop", 32'(wr_en), 32'd0);

    // Asynchronous reset mid-stream
    wr_ready = 1'b0;
    req(1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 2'd0, 4'hA, 4'h0);
    tick();
    in_valid = 1'b0;
    chk("ar.pre_en", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("areset");
    @(negedge clk);
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    tick();
    chk("ar.post_en", 32'(wr_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
